// File: rtl/conv_layer_pkg.sv
// Shared types and sizing helpers for the convolution layer engine.
package conv_layer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } conv_state_t;

  // Number of products accumulated per output pixel.
  function automatic int dot_len(input int kernel_dim, input int chin);
    return kernel_dim * kernel_dim * chin;
  endfunction

  // Accumulator width: full product plus growth for DOT additions.
  function automatic int acc_width(input int width, input int dot);
    return 2 * width + $clog2(dot);
  endfunction

  // Counter width for a modulo-n counter, never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_requant.sv
// One output channel: bias add, round-half-up, saturate to WIDTH bits and an
// optional ReLU, captured in an output register on the load strobe.
// Build option: CONV_MAC_LAYER_RELU_EN clamps negative results to zero.
module conv_requant
  import conv_layer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 14,
  parameter int ACC_W = 42
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic signed [ACC_W-1:0]   acc,
  input  logic signed [2*WIDTH-1:0] bias,
  output logic [WIDTH-1:0]          ofm_q
);

  // Two guard bits keep the bias add and rounding add from overflowing.
  localparam int SW = ACC_W + 2;
  localparam logic signed [SW-1:0] HALF  = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0] MAX_V = SW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);

  logic signed [SW-1:0]    sum;
  logic signed [SW-1:0]    shr;
  logic signed [WIDTH-1:0] sat;
  logic signed [WIDTH-1:0] fin;

  // Bias, round, shift down to the ofm scale and clamp to the word range.
  always_comb begin
    sum = SW'(acc) + SW'(bias);
    shr = (sum + HALF) >>> FRAC;
    if (shr > MAX_V) begin
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (shr < MIN_V) begin
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      sat = shr[WIDTH-1:0];
    end
`ifdef CONV_MAC_LAYER_RELU_EN
    fin = sat[WIDTH-1] ? '0 : sat;
`else
    fin = sat;
`endif
  end

  // Output register holds its value between pixel completions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ofm_q <= '0;
    end else if (load) begin
      ofm_q <= fin;
    end
  end

endmodule

// File: rtl/conv_mac_layer.sv
// Convolution layer engine: streams ifm beats, fetches DSP_NO kernel words per
// beat from an external ROM, accumulates DOT products per pixel and emits a
// requantised ofm vector three cycles after the last beat of each pixel.
// Build option: CONV_MAC_LAYER_RELU_EN (ReLU in the requant stage).
module conv_mac_layer
  import conv_layer_pkg::*;
#(
  parameter int WOUT       = 8,
  parameter int CHIN       = 112,
  parameter int KERNEL_DIM = 3,
  parameter int DSP_NO     = 368,
  parameter int WIDTH      = 16,
  parameter int FRAC       = 14
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                layer_en,
  input  logic                                ifm_valid,
  input  logic [WIDTH-1:0]                    ifm,
  output logic [cnt_width(dot_len(KERNEL_DIM, CHIN))-1:0] weight_addr,
  input  logic [DSP_NO-1:0][WIDTH-1:0]        kernels,
  input  logic [DSP_NO-1:0][2*WIDTH-1:0]      bias,
  input  logic                                ram_feedback,
  output logic [DSP_NO-1:0][WIDTH-1:0]        ofm,
  output logic                                ofm_sample,
  output logic                                busy,
  output logic                                layer_finish
);

  localparam int DOT   = dot_len(KERNEL_DIM, CHIN);
  localparam int ACC_W = acc_width(WIDTH, DOT);
  localparam int AW    = cnt_width(DOT);
  localparam int NPIX  = WOUT * WOUT;
  localparam int PW    = cnt_width(NPIX);

  conv_state_t state_reg, state_next;
  logic [1:0]    drain_cnt_reg;
  logic [AW-1:0] addr_reg;
  logic [PW-1:0] pix_cnt_reg;

  logic accept;
  logic beat_last;
  logic pixel_last;

  // Stage 1 (aligned with ROM data), stage 2 (accumulator), stage 3 (requant).
  logic                    v1_reg;
  logic                    first1_reg;
  logic                    last1_reg;
  logic signed [WIDTH-1:0] ifm_d_reg;
  logic                    done2_reg;
  logic                    sample_reg;

  assign accept     = ifm_valid && layer_en && (state_reg == RUN);
  assign beat_last  = (addr_reg == AW'(DOT - 1));
  assign pixel_last = (pix_cnt_reg == PW'(NPIX - 1));

  assign weight_addr  = addr_reg;
  assign busy         = (state_reg != IDLE);
  assign layer_finish = (state_reg == FINISH);
  assign ofm_sample   = sample_reg;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; DRAIN covers the pipeline tail of the last pixel.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (layer_en) state_next = RUN;
      RUN:     if (accept && beat_last && pixel_last) state_next = DRAIN;
      DRAIN:   if (drain_cnt_reg == 2'd2) state_next = FINISH;
      FINISH:  if (ram_feedback) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain cycle counter, only live while draining.
  always_ff @(posedge clk) begin
    if (!rst || (state_reg != DRAIN)) begin
      drain_cnt_reg <= '0;
    end else begin
      drain_cnt_reg <= drain_cnt_reg + 2'd1;
    end
  end

  // Beat (ROM address) and pixel counters; they only move on accepted beats,
  // so a paused or starved stream leaves a partial pixel intact.
  always_ff @(posedge clk) begin
    if (!rst || (state_reg == IDLE)) begin
      addr_reg    <= '0;
      pix_cnt_reg <= '0;
    end else if (accept) begin
      if (beat_last) begin
        addr_reg    <= '0;
        pix_cnt_reg <= pixel_last ? '0 : pix_cnt_reg + PW'(1);
      end else begin
        addr_reg <= addr_reg + AW'(1);
      end
    end
  end

  // Beat tokens travel with the data so the accumulator needs no clear cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      v1_reg     <= 1'b0;
      first1_reg <= 1'b0;
      last1_reg  <= 1'b0;
      ifm_d_reg  <= '0;
      done2_reg  <= 1'b0;
      sample_reg <= 1'b0;
    end else begin
      v1_reg     <= accept;
      first1_reg <= (addr_reg == '0);
      last1_reg  <= beat_last;
      if (accept) begin
        ifm_d_reg <= ifm;
      end
      done2_reg  <= v1_reg && last1_reg;
      sample_reg <= done2_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DSP_NO; gi++) begin : g_ch
      logic signed [2*WIDTH-1:0] prod;
      logic signed [ACC_W-1:0]   acc_reg;

      assign prod = ifm_d_reg * $signed(kernels[gi]);

      // First beat of a pixel loads the product, later beats add to it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          acc_reg <= '0;
        end else if (v1_reg) begin
          acc_reg <= first1_reg ? ACC_W'(prod) : acc_reg + ACC_W'(prod);
        end
      end

      conv_requant #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
      ) u_requant (
        .clk   (clk),
        .rst   (rst),
        .load  (done2_reg),
        .acc   (acc_reg),
        .bias  (bias[gi]),
        .ofm_q (ofm[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_conv_mac_layer.sv
// Self-checking bench for conv_mac_layer (small configuration). A frame-level
// model predicts every strobe, ofm value, address and status flag per cycle.
module tb_conv_mac_layer;

  localparam int WOUT = 2, CHIN = 4, KD = 1, NCH = 2, W = 16, FRAC = 8;
  localparam int DOT = KD * KD * CHIN;
  localparam int NPIX = WOUT * WOUT;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_FINISH = 3;

  logic clk = 1'b0;
  logic rst, layer_en, ifm_valid, ram_feedback;
  logic [W-1:0] ifm;
  logic [1:0] weight_addr;
  logic [NCH-1:0][W-1:0] kernels;
  logic [NCH-1:0][2*W-1:0] bias;
  logic [NCH-1:0][W-1:0] ofm;
  logic ofm_sample, busy, layer_finish;

  logic [NCH-1:0][W-1:0] rom [DOT];

  always #5 clk = ~clk;

  // External weight ROM with one registered cycle of latency.
  always @(posedge clk) kernels <= rom[weight_addr];

  conv_mac_layer #(
    .WOUT(WOUT), .CHIN(CHIN), .KERNEL_DIM(KD), .DSP_NO(NCH), .WIDTH(W), .FRAC(FRAC)
  ) dut (
    .clk(clk), .rst(rst), .layer_en(layer_en), .ifm_valid(ifm_valid), .ifm(ifm),
    .weight_addr(weight_addr), .kernels(kernels), .bias(bias),
    .ram_feedback(ram_feedback), .ofm(ofm), .ofm_sample(ofm_sample),
    .busy(busy), .layer_finish(layer_finish)
  );

  typedef struct packed {
    int                    due;
    logic [NCH-1:0][W-1:0] v;
  } exp_t;

  int total = 0, bad = 0;
  int cyc = 0;
  bit chk_on = 0;
  int m_state, m_addr, m_beat, m_pix, m_drain;
  longint m_acc [NCH];
  logic [NCH-1:0][W-1:0] m_ofm, got_ofm;
  exp_t exp_q [$];
  int strobe_cyc [$];
  logic [W-1:0] ifm_fix;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got=%0h want=%0h", nm, cyc, got, exp);
    end
  endtask

  // Requantise: add bias, round half up at FRAC, saturate, optional ReLU.
  function automatic logic [W-1:0] rq(input longint a, input longint b);
    longint s, r, d;
    d = longint'(1) << FRAC;
    s = a + b + d / 2;
    if (s >= 0) r = s / d;
    else r = -((-s + d - 1) / d);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef CONV_MAC_LAYER_RELU_EN
    if (r < 0) r = 0;
`endif
    return W'(r);
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_addr = 0; m_beat = 0; m_pix = 0; m_drain = 0;
    m_ofm = '0;
    exp_q.delete();
  endtask

  // Model of the frame: samples inputs at each rising edge.
  task automatic model_step();
    bit acc_now, frame_done;
    exp_t e;
    frame_done = 0;
    if (!rst) begin
      model_reset();
    end else begin
      acc_now = (m_state == S_RUN) && ifm_valid && layer_en;
      if (acc_now) begin
        for (int c = 0; c < NCH; c++) begin
          if (m_beat == 0) m_acc[c] = 0;
          m_acc[c] += longint'($signed(ifm)) * longint'($signed(rom[m_addr][c]));
        end
        m_beat++;
        m_addr = (m_addr + 1) % DOT;
        if (m_beat == DOT) begin
          e.due = cyc + 3;
          for (int c = 0; c < NCH; c++) e.v[c] = rq(m_acc[c], longint'($signed(bias[c])));
          exp_q.push_back(e);
          m_beat = 0;
          m_pix++;
          if (m_pix == NPIX) begin m_pix = 0; frame_done = 1; end
        end
      end
      case (m_state)
        S_IDLE:   if (layer_en) begin m_state = S_RUN; m_addr = 0; end
        S_RUN:    if (frame_done) begin m_state = S_DRAIN; m_drain = 0; end
        S_DRAIN:  begin m_drain++; if (m_drain == 3) m_state = S_FINISH; end
        default:  if (ram_feedback) m_state = S_IDLE;
      endcase
    end
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      bit es;
      es = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("ofm_sample", 64'(ofm_sample), 64'(es));
      if (es) begin
        m_ofm = exp_q[0].v;
        void'(exp_q.pop_front());
      end
      if (ofm_sample) begin
        strobe_cyc.push_back(cyc);
        got_ofm = ofm;
      end
      chk("ofm", 64'(ofm), 64'(m_ofm));
      chk("weight_addr", 64'(weight_addr), 64'(m_addr));
      chk("busy", 64'(busy), 64'(m_state != S_IDLE));
      chk("layer_finish", 64'(layer_finish), 64'(m_state == S_FINISH));
    end
  end

  task automatic set_rom(input logic [W-1:0] k0, input logic [W-1:0] k1);
    for (int a = 0; a < DOT; a++) begin rom[a][0] = k0; rom[a][1] = k1; end
  endtask

  // Runs one frame; mode 0 drives ifm_fix, mode 1 random ifm.
  task automatic run_frame(input int gap, input bit pause, input int fb_delay,
                           input bit fb_early, input bit mode);
    int budget;
    bit paused;
    paused = 0;
    budget = 0;
    strobe_cyc.delete();
    @(negedge clk);
    layer_en = 1'b1;
    ram_feedback = fb_early;
    while (m_state != S_FINISH && budget < 600) begin
      if (pause && !paused && m_state == S_RUN && m_beat == 2) begin
        layer_en = 1'b0;
        repeat (5) begin
          ifm_valid = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
        layer_en = 1'b1;
        paused = 1;
      end
      ifm_valid = ($urandom_range(0, 99) >= gap);
      ifm = mode ? W'($urandom) : ifm_fix;
      @(negedge clk);
      budget++;
    end
    if (budget >= 600) chk("frame_timeout", 64'(budget), 64'(0));
    ifm_valid = 1'b0;
    layer_en = 1'b0;
    if (fb_early) begin
      repeat (3) @(negedge clk);
      ram_feedback = 1'b0;
    end else begin
      repeat (fb_delay) @(negedge clk);
      chk("finish_held", 64'(layer_finish), 64'(1));
      ram_feedback = 1'b1;
      @(negedge clk);
      ram_feedback = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_after_fb", 64'(busy), 64'(0));
    end
    chk("strobes_per_frame", 64'(strobe_cyc.size()), 64'(NPIX));
  endtask

  task automatic reset_when(input int beats, input bit after_pixel);
    int budget;
    budget = 0;
    @(negedge clk);
    layer_en = 1'b1;
    ifm_valid = 1'b1;
    ifm = 16'd256;
    while (budget < 50 && !(after_pixel ? exp_q.size() > 0 :
                             (m_state == S_RUN && m_beat == beats))) begin
      @(negedge clk);
      budget++;
    end
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ofm", 64'(ofm), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_addr", 64'(weight_addr), 64'(0));
    chk("rst_sample", 64'(ofm_sample), 64'(0));
    rst = 1'b1;
    layer_en = 1'b0;
    ifm_valid = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; layer_en = 1'b0; ifm_valid = 1'b0; ifm = '0;
    ram_feedback = 1'b0; bias = '0; ifm_fix = '0;
    m_ofm = '0; got_ofm = '0;
    set_rom(16'd256, 16'd256);
    repeat (3) @(negedge clk);
    chk_on = 1;
    chk("reset_ofm", 64'(ofm), 64'(0));
    chk("reset_sample", 64'(ofm_sample), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_finish", 64'(layer_finish), 64'(0));
    chk("reset_addr", 64'(weight_addr), 64'(0));
    rst = 1'b1;

    // Unity, continuous valid.
    ifm_fix = 16'd256;
    run_frame(0, 0, 10, 0, 0);
    chk("unity_ch0", 64'(got_ofm[0]), 64'(1024));
    chk("unity_ch1", 64'(got_ofm[1]), 64'(1024));
    for (int i = 0; i + 1 < strobe_cyc.size(); i++)
      chk("unity_spacing", 64'(strobe_cyc[i+1] - strobe_cyc[i]), 64'(4));

    // Negative kernel and round-half-up.
    set_rom(16'd256, 16'hFF00);
    bias[0] = 32'd128;
    run_frame(0, 0, 3, 0, 0);
    chk("round_ch0", 64'(got_ofm[0]), 64'(1025));
`ifdef CONV_MAC_LAYER_RELU_EN
    chk("neg_ch1", 64'(got_ofm[1]), 64'(0));
`else
    chk("neg_ch1", 64'(got_ofm[1]), 64'(16'hFC00));
`endif

    // Positive and negative saturation.
    set_rom(16'h7FFF, 16'h7FFF);
    bias = '0;
    ifm_fix = 16'h7FFF;
    run_frame(0, 0, 2, 0, 0);
    chk("sat_pos", 64'(got_ofm[0]), 64'(16'h7FFF));
    ifm_fix = 16'h8000;
    run_frame(0, 0, 2, 0, 0);
`ifdef CONV_MAC_LAYER_RELU_EN
    chk("sat_neg", 64'(got_ofm[0]), 64'(0));
`else
    chk("sat_neg", 64'(got_ofm[0]), 64'(16'h8000));
`endif

    // Stalls plus a layer_en pause mid-pixel, then an early feedback frame.
    set_rom(16'd256, 16'd256);
    ifm_fix = 16'd256;
    run_frame(40, 1, 10, 0, 0);
    chk("stall_ch0", 64'(got_ofm[0]), 64'(1024));
    chk("stall_ch1", 64'(got_ofm[1]), 64'(1024));
    run_frame(20, 0, 0, 1, 0);
    chk("rearm_ch0", 64'(got_ofm[0]), 64'(1024));

    // Reset mid-pixel and with a finished pixel still in flight.
    reset_when(2, 0);
    reset_when(0, 1);
    run_frame(0, 0, 1, 0, 0);
    chk("post_rst_ch1", 64'(got_ofm[1]), 64'(1024));

    // Randomised weights, bias, pixels and stream gaps.
    for (int f = 0; f < 6; f++) begin
      int fd;
      for (int a = 0; a < DOT; a++)
        for (int c = 0; c < NCH; c++) rom[a][c] = W'($urandom);
      for (int c = 0; c < NCH; c++) bias[c] = $urandom;
      fd = $urandom_range(0, 5);
      run_frame($urandom_range(0, 50), f[0], fd, (fd == 0), 1);
    end

    repeat (4) @(negedge clk);
    chk("no_pending", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
